// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator slice.
//   state_t     : accumulator controller states (ACC, RESOLVE, OUT)
//   calc_k      : number of CHUNK-wide slices in the final carry-propagate add
//   idx_width   : width of the slice index register (at least 1 bit)
//   params_ok   : legality of a W / ACC_W / CHUNK combination, used at elaboration
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  function automatic int calc_k(input int acc_w, input int chunk);
    return acc_w / chunk;
  endfunction

  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic bit params_ok(input int w, input int acc_w, input int chunk);
    return (w > 0) && (chunk > 0) && (acc_w >= 2) &&
           ((acc_w % chunk) == 0) && (w <= acc_w);
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand/result handshake bundle for csa_accumulator.
//   in_valid/in_ready/in_data/in_last   : operand stream (valid/ready)
//   out_valid/out_ready                 : result handshake
//   out_data/out_count/out_ovf          : resolved sum, operand count, overflow
// slave  : the accumulator side
// master : the producer/consumer side driving operands and accepting results
interface csa_accumulator_if #(
  parameter int W     = 6,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/csa_row.sv
// ACC_W-bit 3:2 compressor row (purely combinational).
//   a, b, c : three addends
//   sum     : bitwise a^b^c
//   maj     : bitwise majority, NOT shifted; the caller applies the <<1 weight
module csa_row #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] sum,
  output logic [ACC_W-1:0] maj
);

  assign sum = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand carry-save accumulator.
// Folds one unsigned operand per accepted beat into a redundant (S, C) pair,
// then on the last beat resolves S + C with a K-cycle chunked ripple add and
// presents the result with operand count and exact overflow.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : csa_accumulator_if.slave (operand stream in, result out)
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int W     = 6,
  parameter int ACC_W = 12,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_accumulator_if.slave bus
);

  localparam int               K        = calc_k(ACC_W, CHUNK);
  localparam int               IDX_W    = idx_width(K);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

  if (!params_ok(W, ACC_W, CHUNK)) begin : g_param_check
    $error("csa_accumulator: ACC_W must be a multiple of CHUNK and W <= ACC_W");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t state_q, state_nxt;

  logic [ACC_W-1:0] s_q, c_q, res_q, res_upd;
  logic [ACC_W-1:0] x, row_sum, row_maj;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [IDX_W-1:0] idx_q;
  logic             cy_q;

  logic [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] s_chunk, c_chunk;
  logic [CHUNK:0]   chunk_sum;

  assign accept     = bus.in_valid && (state_q == ACC);
  assign last_chunk = (idx_q == IDX_LAST);
  assign x          = ACC_W'(bus.in_data);

  csa_row #(.ACC_W(ACC_W)) u_row (
    .a   (s_q),
    .b   (c_q),
    .c   (x),
    .sum (row_sum),
    .maj (row_maj)
  );

  // Resolve stage: one CHUNK-wide slice of S + C per cycle, carry held in cy_q
  assign s_chunk   = s_q[idx_q*CHUNK +: CHUNK];
  assign c_chunk   = c_q[idx_q*CHUNK +: CHUNK];
  assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    res_upd = res_q;
    res_upd[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ACC:     if (accept && bus.in_last) state_nxt = RESOLVE;
      RESOLVE: if (last_chunk)            state_nxt = OUT;
      OUT:     if (bus.out_ready)         state_nxt = ACC;
      default:                            state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        // Accumulate stage: the majority vector carries weight 2, so its MSB
        // leaves the ACC_W window and is folded into the overflow flag.
        ACC: begin
          if (accept) begin
            s_q   <= row_sum;
            c_q   <= {row_maj[ACC_W-2:0], 1'b0};
            ovf_q <= ovf_q | row_maj[ACC_W-1];
            cnt_q <= sat_inc(cnt_q);
            if (bus.in_last) begin
              idx_q <= '0;
              cy_q  <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res_q <= res_upd;
          cy_q  <= chunk_sum[CHUNK];
          idx_q <= idx_q + 1'b1;
          if (last_chunk) begin
            ovf_q       <= ovf_q | chunk_sum[CHUNK];
            out_data_q  <= res_upd;
            out_count_q <= cnt_q;
            out_ovf_q   <= ovf_q | chunk_sum[CHUNK];
          end
        end
        // Output stage: results stay on the registered outputs after handoff
        OUT: begin
          if (bus.out_ready) begin
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed testbench for csa_accumulator (W=6, ACC_W=12, CHUNK=4, K=3).
// Inputs change and outputs are sampled on the falling edge.
module tb_csa_accumulator;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  csa_accumulator_if #(.W(6), .ACC_W(12), .CNT_W(8)) ifc ();

  csa_accumulator #(.W(6), .ACC_W(12), .CHUNK(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present one beat, wait (bounded) for in_ready, let it be taken on the
  // next rising edge; returns on the falling edge after acceptance.
  task automatic send_beat(input logic [5:0] d, input logic last);
    int g;
    g = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = last;
    while (!ifc.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("beat_ready", ifc.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_data, input int exp_cnt,
                             input int exp_ovf);
    int g;
    g = 0;
    while (!ifc.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_valid"}, ifc.out_valid, 1);
    check({tag, "_data"},  ifc.out_data,  exp_data);
    check({tag, "_count"}, ifc.out_count, exp_cnt);
    check({tag, "_ovf"},   ifc.out_ovf,   exp_ovf);
    if (ifc.out_valid && ifc.out_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  ifc.in_ready,  1);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data",  ifc.out_data,  0);
    check("rst_out_count", ifc.out_count, 0);
    check("rst_out_ovf",   ifc.out_ovf,   0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 40 + 25 + 20 with latency check
    send_beat(6'd40, 1'b0);
    send_beat(6'd25, 1'b0);
    send_beat(6'd20, 1'b1);
    for (int n = 1; n <= 3; n++) begin
      check("lat_in_ready",  ifc.in_ready,  0);
      check("lat_out_valid", ifc.out_valid, 0);
      @(negedge clk);
    end
    check("lat_valid_at_4", ifc.out_valid, 1);
    wait_result("basic", 85, 3, 0);

    // Wrap: 65 x 63 = 4095, 66 x 63 = 4158 -> 62 with overflow
    for (int i = 0; i < 65; i++) send_beat(6'd63, (i == 64));
    wait_result("wrap65", 4095, 65, 0);
    for (int i = 0; i < 66; i++) send_beat(6'd63, (i == 65));
    wait_result("wrap66", 62, 66, 1);

    // Backpressure: result 6 held while out_ready=0, no operand absorbed
    ifc.out_ready = 1'b0;
    send_beat(6'd1, 1'b0);
    send_beat(6'd2, 1'b0);
    send_beat(6'd3, 1'b1);
    begin
      int g;
      g = 0;
      while (!ifc.out_valid && g < 50) begin
        @(negedge clk);
        g++;
      end
    end
    check("bp_count", ifc.out_count, 3);
    check("bp_ovf",   ifc.out_ovf,   0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 6'd9;
    ifc.in_last  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      check("bp_valid",    ifc.out_valid, 1);
      check("bp_data",     ifc.out_data,  6);
      check("bp_in_ready", ifc.in_ready,  0);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_acc_ready", ifc.in_ready, 1);
    check("bp_hold_data", ifc.out_data, 6);
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    wait_result("bp_next", 9, 1, 0);

    // Bubbles between beats
    send_beat(6'd10, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(6'd20, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(6'd30, 1'b1);
    wait_result("bubbles", 60, 3, 0);

    // Reset during the second RESOLVE cycle
    send_beat(6'd10, 1'b0);
    send_beat(6'd20, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready",  ifc.in_ready,  1);
    check("mid_rst_out_data",  ifc.out_data,  0);
    check("mid_rst_out_count", ifc.out_count, 0);
    for (int n = 0; n < 6; n++) begin
      check("mid_rst_no_valid", ifc.out_valid, 0);
      @(negedge clk);
    end
    send_beat(6'd7, 1'b1);
    wait_result("after_rst", 7, 1, 0);

    // Single zero beat
    send_beat(6'd0, 1'b1);
    wait_result("zero", 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
